serdesphy_rx_aligner: RTL and testbench

- RX PCS front stage in the clk_240m_rx domain.
- Consumes the bit stream that the PMA deserializer interface delivers as rx_serial_data/rx_serial_valid/rx_serial_error.
- Finds frame boundaries using a sync word and qualifies lock with a SEARCH/VERIFY/LOCKED FSM.
- Emits 4-bit data nibbles plus rx_aligned status to the RX FIFO and CSR status path.

---
 rtl/serdesphy_pcs_pkg.sv | 20 ++
 rtl/serdesphy_rx_aligner_if.sv | 26 ++
 rtl/serdesphy_sync_detect.sv | 37 +++
 rtl/serdesphy_rx_aligner.sv | 151 +++++++++++++++
 tb/tb_serdesphy_rx_aligner.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serdesphy_pcs_pkg.sv
// Shared PCS types and constants for the RX alignment path.
package serdesphy_pcs_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SYNC_W   = 8;

  localparam logic [SYNC_W-1:0] SYNC_WORD_DEF = 8'hB4;

  typedef enum logic [1:0] {
    ALIGN_SEARCH = 2'd0,
    ALIGN_VERIFY = 2'd1,
    ALIGN_LOCKED = 2'd2
  } align_state_e;

  typedef struct packed {
    logic [NIBBLE_W-1:0] data;
    logic                err;
  } nibble_t;

endpackage

// File: rtl/serdesphy_rx_aligner_if.sv
// Serial bit input, control and nibble/status output bundle of the RX aligner.
interface serdesphy_rx_aligner_if;
  import serdesphy_pcs_pkg::*;

  logic                rx_en;
  logic                rx_align_rst;
  logic                rx_serial_data;
  logic                rx_serial_valid;
  logic                rx_serial_error;
  logic [NIBBLE_W-1:0] rx_nibble;
  logic                rx_nibble_valid;
  logic                rx_nibble_err;
  logic                rx_aligned;
  logic [1:0]          align_state;
  logic                rx_error;

  modport master (
    output rx_en, rx_align_rst, rx_serial_data, rx_serial_valid, rx_serial_error,
    input  rx_nibble, rx_nibble_valid, rx_nibble_err, rx_aligned, align_state, rx_error
  );

  modport slave (
    input  rx_en, rx_align_rst, rx_serial_data, rx_serial_valid, rx_serial_error,
    output rx_nibble, rx_nibble_valid, rx_nibble_err, rx_aligned, align_state, rx_error
  );
endinterface

// File: rtl/serdesphy_sync_detect.sv
// Bit shift register with fill qualification and sync-word comparator.
module serdesphy_sync_detect
  import serdesphy_pcs_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_clr,
  input  logic              bit_en,
  input  logic              d,
  output logic [SYNC_W-1:0] nxt,
  output logic              sync_hit
);

  localparam int unsigned FILL_W = $clog2(SYNC_W + 1);

  logic [SYNC_W-1:0] sr;
  logic [FILL_W-1:0] fill_cnt;

  assign nxt      = {sr[SYNC_W-2:0], d};
  // Detection only once the register holds eight real bits, never reset zeros.
  assign sync_hit = (fill_cnt == FILL_W'(SYNC_W)) && (nxt == SYNC_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      fill_cnt <= '0;
    end else if (fill_clr) begin
      fill_cnt <= '0;
    end else if (bit_en) begin
      sr <= nxt;
      if (fill_cnt != FILL_W'(SYNC_W)) fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

endmodule

// File: rtl/serdesphy_rx_aligner.sv
// RX frame aligner: sync search/verify/lock FSM, frame bit counter and nibble assembly.
module serdesphy_rx_aligner
  import serdesphy_pcs_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned       FRAME_NIB = 4,
  parameter int unsigned       LOCK_CNT  = 3,
  parameter int unsigned       LOSS_CNT  = 4
) (
  input logic                   clk_240m_rx,
  input logic                   rst_n_240m_rx,
  serdesphy_rx_aligner_if.slave rx
);

  localparam int unsigned DATA_BITS  = NIBBLE_W * FRAME_NIB;
  localparam int unsigned FRAME_BITS = SYNC_W + DATA_BITS;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned HIT_W      = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W     = $clog2(LOSS_CNT + 1);

  align_state_e      state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [HIT_W-1:0]  hit_cnt, hit_cnt_nxt, hit_inc;
  logic [MISS_W-1:0] miss_cnt, miss_cnt_nxt, miss_inc;
  logic              err_acc, err_acc_nxt;
  logic              rx_error_q, rx_error_nxt;
  nibble_t           nib_q, nib_nxt;
  logic              nib_vld_q, nib_vld_nxt;
  logic              aligned_q;

  logic              clr, bit_en, sync_match, at_sync, in_data;
  logic [SYNC_W-1:0] nxt;
  logic              sync_hit;

  assign clr        = rx.rx_align_rst | ~rx.rx_en;
  assign bit_en     = rx.rx_serial_valid & ~clr;
  assign sync_match = (nxt == SYNC_WORD);
  assign at_sync    = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign in_data    = (bit_cnt < BIT_W'(DATA_BITS));
  assign hit_inc    = hit_cnt + HIT_W'(1);
  assign miss_inc   = miss_cnt + MISS_W'(1);

  serdesphy_sync_detect #(.SYNC_WORD(SYNC_WORD)) u_sync_detect (
    .clk      (clk_240m_rx),
    .rst_n    (rst_n_240m_rx),
    .fill_clr (clr),
    .bit_en   (bit_en),
    .d        (rx.rx_serial_data),
    .nxt      (nxt),
    .sync_hit (sync_hit)
  );

  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      state      <= ALIGN_SEARCH;
      bit_cnt    <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      err_acc    <= 1'b0;
      rx_error_q <= 1'b0;
      nib_q      <= '0;
      nib_vld_q  <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      hit_cnt    <= hit_cnt_nxt;
      miss_cnt   <= miss_cnt_nxt;
      err_acc    <= err_acc_nxt;
      rx_error_q <= rx_error_nxt;
      nib_q      <= nib_nxt;
      nib_vld_q  <= nib_vld_nxt;
      aligned_q  <= (state_nxt == ALIGN_LOCKED);
    end
  end

  // Next-state, counters and nibble assembly; invalid cycles fall through holding state.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    hit_cnt_nxt  = hit_cnt;
    miss_cnt_nxt = miss_cnt;
    err_acc_nxt  = err_acc;
    rx_error_nxt = rx_error_q;
    nib_nxt      = nib_q;
    nib_nxt.err  = 1'b0;
    nib_vld_nxt  = 1'b0;

    if (clr) begin
      state_nxt    = ALIGN_SEARCH;
      bit_cnt_nxt  = '0;
      hit_cnt_nxt  = '0;
      miss_cnt_nxt = '0;
      err_acc_nxt  = 1'b0;
      if (rx.rx_align_rst) rx_error_nxt = 1'b0;
    end else if (rx.rx_serial_valid) begin
      case (state)
        ALIGN_SEARCH: begin
          if (sync_hit) begin
            state_nxt   = ALIGN_VERIFY;
            hit_cnt_nxt = HIT_W'(1);
            bit_cnt_nxt = '0;
            err_acc_nxt = 1'b0;
          end
        end
        ALIGN_VERIFY, ALIGN_LOCKED: begin
          bit_cnt_nxt = at_sync ? '0 : bit_cnt + BIT_W'(1);
          if (at_sync) begin
            if (state == ALIGN_VERIFY) begin
              if (!sync_match) begin
                state_nxt = ALIGN_SEARCH;
              end else begin
                hit_cnt_nxt = hit_inc;
                if (hit_inc == HIT_W'(LOCK_CNT)) begin
                  state_nxt    = ALIGN_LOCKED;
                  miss_cnt_nxt = '0;
                end
              end
            end else if (sync_match) begin
              miss_cnt_nxt = '0;
            end else begin
              miss_cnt_nxt = miss_inc;
              if (miss_inc == MISS_W'(LOSS_CNT)) begin
                state_nxt    = ALIGN_SEARCH;
                rx_error_nxt = 1'b1;
              end
            end
          end else if (state == ALIGN_LOCKED && in_data) begin
            if (bit_cnt[1:0] == 2'd3) begin
              nib_nxt.data = nxt[NIBBLE_W-1:0];
              nib_nxt.err  = err_acc | rx.rx_serial_error;
              nib_vld_nxt  = 1'b1;
              err_acc_nxt  = 1'b0;
            end else begin
              err_acc_nxt = err_acc | rx.rx_serial_error;
            end
          end
        end
        default: state_nxt = ALIGN_SEARCH;
      endcase
    end
  end

  assign rx.rx_nibble       = nib_q.data;
  assign rx.rx_nibble_err   = nib_q.err;
  assign rx.rx_nibble_valid = nib_vld_q;
  assign rx.rx_aligned      = aligned_q;
  assign rx.align_state     = state;
  assign rx.rx_error        = rx_error_q;

endmodule

// File: tb/tb_serdesphy_rx_aligner.sv
// Scoreboard bench for serdesphy_rx_aligner against a bit-history reference model.
module tb_serdesphy_rx_aligner;
  import serdesphy_pcs_pkg::*;

  localparam int FB = 24;
  localparam int DB = 16;
  localparam logic [7:0] SYNC = 8'hB4;

  typedef struct packed {
    logic [1:0] st;
    logic       al;
    logic       er;
    logic       v;
    logic [3:0] nib;
    logic       ne;
  } stat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #2 clk = ~clk;

  serdesphy_rx_aligner_if ifc();

  serdesphy_rx_aligner dut (
    .clk_240m_rx   (clk),
    .rst_n_240m_rx (rst_n),
    .rx            (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  stat_t      q_stat[$];
  logic [4:0] q_nib[$];

  bit cur_en = 1'b0;
  int gap_mode = 0;

  // Reference model state: plain integers and a bit-history window.
  int   m_st, m_since, m_pos, m_hits, m_miss;
  bit   m_err, m_nerr;
  bit   m_hist[$];
  bit   m_nib_bits[$];
  logic [3:0] m_last_nib;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] hist_word();
    logic [7:0] w = 8'h00;
    foreach (m_hist[i]) w = {w[6:0], m_hist[i]};
    return w;
  endfunction

  task automatic model_reset();
    m_st = 0; m_since = 0; m_pos = 0; m_hits = 0; m_miss = 0;
    m_err = 0; m_nerr = 0; m_last_nib = 4'h0;
    m_hist.delete(); m_nib_bits.delete();
  endtask

  task automatic model_step(input bit v, input bit d, input bit e, input bit ar,
                            input bit en, output stat_t s);
    bit match;
    int p;
    s = '0;
    if (ar || !en) begin
      m_st = 0; m_since = 0; m_pos = 0; m_hits = 0; m_miss = 0;
      m_nib_bits.delete(); m_nerr = 0;
      if (ar) m_err = 0;
    end else if (v) begin
      m_hist.push_back(d);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      m_since++;
      match = (hist_word() == SYNC);
      if (m_st == 0) begin
        if (m_since > 8 && match) begin
          m_st = 1; m_hits = 1; m_pos = 0;
        end
      end else begin
        p = m_pos;
        m_pos = (m_pos + 1) % FB;
        if (p == FB - 1) begin
          if (m_st == 1) begin
            if (match) begin
              m_hits++;
              if (m_hits == 3) begin m_st = 2; m_miss = 0; end
            end else m_st = 0;
          end else if (match) begin
            m_miss = 0;
          end else begin
            m_miss++;
            if (m_miss == 4) begin m_st = 0; m_err = 1; m_nib_bits.delete(); m_nerr = 0; end
          end
        end else if (m_st == 2 && p < DB) begin
          m_nib_bits.push_back(d);
          m_nerr |= e;
          if (m_nib_bits.size() == 4) begin
            m_last_nib = {m_nib_bits[0], m_nib_bits[1], m_nib_bits[2], m_nib_bits[3]};
            s.v  = 1'b1;
            s.ne = m_nerr;
            q_nib.push_back({m_last_nib, m_nerr});
            m_nib_bits.delete();
            m_nerr = 0;
          end
        end
      end
    end
    s.st  = 2'(m_st);
    s.al  = (m_st == 2);
    s.er  = m_err;
    s.nib = m_last_nib;
  endtask

  task automatic step(input bit v, input bit d, input bit e, input bit ar);
    stat_t s;
    @(negedge clk);
    ifc.rx_en           = cur_en;
    ifc.rx_align_rst    = ar;
    ifc.rx_serial_valid = v;
    ifc.rx_serial_data  = d;
    ifc.rx_serial_error = e;
    model_step(v, d, e, ar, cur_en, s);
    q_stat.push_back(s);
  endtask

  task automatic send_bit(input bit d, input bit e);
    int n;
    n = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (n) step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
    step(1'b1, d, e, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] emask);
    for (int i = 7; i >= 0; i--) send_bit(b[i], emask[i]);
  endtask

  task automatic send_frame(input logic [7:0] sync, input logic [15:0] data, input logic [15:0] emask);
    send_byte(sync, 8'h00);
    for (int i = 15; i >= 0; i--) send_bit(data[i], emask[i]);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    ifc.rx_serial_valid = 1'b0;
    ifc.rx_align_rst    = 1'b0;
    ifc.rx_en           = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", 16'({ifc.align_state, ifc.rx_aligned, ifc.rx_error,
                               ifc.rx_nibble_valid, ifc.rx_nibble, ifc.rx_nibble_err}), 16'h0);
    model_reset();
    q_stat.delete();
    q_nib.delete();
    cur_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every post-edge sample pops one expected status; strobes pop the nibble queue.
  always begin : monitor
    stat_t      exp_s;
    stat_t      act_s;
    logic [4:0] exp_n;
    @(posedge clk);
    #1;
    if (rst_n && q_stat.size() > 0) begin
      exp_s = q_stat.pop_front();
      act_s = {ifc.align_state, ifc.rx_aligned, ifc.rx_error, ifc.rx_nibble_valid,
               ifc.rx_nibble, ifc.rx_nibble_err};
      check("status", 16'(act_s), 16'(exp_s));
      if (ifc.rx_nibble_valid) begin
        if (q_nib.size() == 0) begin
          n_checks++;
          $display("FAIL nibble_unexpected: got %h with no expected nibble at %0t",
                   ifc.rx_nibble, $time);
        end else begin
          exp_n = q_nib.pop_front();
          check("nibble", 16'({ifc.rx_nibble, ifc.rx_nibble_err}), 16'(exp_n));
        end
      end
    end
  end

  initial begin
    logic [15:0] emask;
    logic [7:0]  sync;
    ifc.rx_en = 1'b0; ifc.rx_align_rst = 1'b0;
    ifc.rx_serial_valid = 1'b0; ifc.rx_serial_data = 1'b0; ifc.rx_serial_error = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 16'({ifc.align_state, ifc.rx_aligned, ifc.rx_error,
                                ifc.rx_nibble_valid, ifc.rx_nibble, ifc.rx_nibble_err}), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled: toggling bits never leave SEARCH.
    for (int i = 0; i < 12; i++) step(1'b1, 1'(i), 1'b0, 1'b0);

    // Acquisition, continuous valid.
    cur_en = 1'b1;
    gap_mode = 0;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    for (int f = 0; f < 5; f++) send_frame(SYNC, 16'h1234, 16'h0);
    settle();
    check("acq_locked", 16'(ifc.align_state), 16'd2);

    // Asynchronous reset mid-frame, then disabled toggling.
    send_byte(SYNC, 8'h00);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'(i + 1), 1'b0, 1'b0);

    // Same stream with valid every third cycle.
    cur_en = 1'b1;
    gap_mode = 1;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    for (int f = 0; f < 5; f++) send_frame(SYNC, 16'h1234, 16'h0);
    settle();
    check("gap_locked", 16'(ifc.align_state), 16'd2);

    // Three misses then a hit keep lock.
    gap_mode = 0;
    for (int f = 0; f < 3; f++) send_frame(8'h00, 16'h1234, 16'h0);
    send_frame(SYNC, 16'h1234, 16'h0);
    settle();
    check("miss3_aligned", 16'({ifc.rx_aligned, ifc.rx_error}), 16'b10);

    // Four misses lose lock.
    for (int f = 0; f < 3; f++) send_frame(8'h00, 16'h1234, 16'h0);
    send_byte(8'h00, 8'h00);
    settle();
    check("loss_flags", 16'({ifc.rx_aligned, ifc.rx_error}), 16'b01);
    for (int i = 15; i >= 0; i--) send_bit(1'(16'h1234 >> i), 1'b0);

    // Relock, then align reset on frame bit 10 with a valid bit.
    for (int f = 0; f < 3; f++) send_frame(SYNC, 16'h1234, 16'h0);
    send_byte(SYNC, 8'h00);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check("alrst_state", 16'({ifc.align_state, ifc.rx_error}), 16'h0);
    for (int i = 12; i >= 0; i--) send_bit(1'(16'h1234 >> i), 1'b0);
    for (int f = 0; f < 3; f++) send_frame(SYNC, 16'h1234, 16'h0);
    settle();
    check("relock", 16'(ifc.rx_aligned), 16'd1);

    // Error on second bit of nibble 2, plus errors on sync bits that must be ignored.
    send_frame(SYNC, 16'h1234, 16'h0400);
    send_byte(SYNC, 8'hFF);
    for (int i = 15; i >= 0; i--) send_bit(1'(16'h5A3C >> i), 1'b0);

    // Randomised frames, gaps, errors and occasional corrupted syncs.
    gap_mode = 2;
    for (int f = 0; f < 40; f++) begin
      emask = '0;
      for (int i = 0; i < 16; i++) emask[i] = ($urandom_range(0, 7) == 0);
      sync = ($urandom_range(0, 5) == 0) ? 8'($urandom) : SYNC;
      send_byte(sync, 8'($urandom));
      for (int i = 15; i >= 0; i--) send_bit(1'($urandom), emask[i]);
    end

    gap_mode = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    settle();
    check("nibble_drain", 16'(q_nib.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
